// File: rtl/keypad_pkg.sv
// Shared definitions for the keypad event controller: FSM encoding,
// key_code field positions and event word layout.
package keypad_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_DB_PRESS = 2'd1,
        ST_HELD     = 2'd2,
        ST_DB_REL   = 2'd3
    } kp_state_t;

    // key_code layout: [4] key present, [3:0] key value
    localparam int KC_W       = 5;
    localparam int KC_PRESENT = 4;
    localparam int KC_KEY_MSB = 3;
    localparam int KC_KEY_LSB = 0;
    localparam int KEY_W      = KC_KEY_MSB - KC_KEY_LSB + 1;

    // event layout: [4] kind, [3:0] key
    localparam int   EV_W       = 5;
    localparam logic EV_PRESS   = 1'b1;
    localparam logic EV_RELEASE = 1'b0;

    typedef logic [KEY_W-1:0] key_t;
    typedef logic [EV_W-1:0]  event_t;

    function automatic event_t make_event(input logic kind, input key_t key);
        return {kind, key};
    endfunction

endpackage

// File: rtl/keypad_evt_fifo.sv
// First-word-fall-through event queue with sticky overflow flag.
// A push into a full queue is accepted only when a pop frees a slot in the same cycle.
module keypad_evt_fifo
    import keypad_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  event_t                   push_data,
    input  logic                     ready,
    output logic                     valid,
    output event_t                   head,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    input  logic                     ovf_clr
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

    event_t         mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic [AW:0]    cnt_q;
    logic           ovf_q;

    logic full;
    logic pop;
    logic wr_en;
    logic drop;

    assign full  = (cnt_q == FULL_CNT);
    assign valid = (cnt_q != '0);
    assign pop   = valid && ready;
    assign wr_en = push && (!full || pop);
    assign drop  = push && full && !pop;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt_q  <= '0;
            ovf_q  <= 1'b0;
        end else begin
            // power-of-two depth: pointer increment wraps on its own
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (pop)   rd_ptr <= rd_ptr + 1'b1;
            case ({wr_en, pop})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
            if (drop)         ovf_q <= 1'b1;
            else if (ovf_clr) ovf_q <= 1'b0;
        end
    end

    // NOTE: storage is not reset; occupancy tracking alone decides which entries are meaningful.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= push_data;
    end

    // empty queue shows zero rather than a stale slot
    assign head     = valid ? mem[rd_ptr] : '0;
    assign count    = cnt_q;
    assign overflow = ovf_q;

endmodule

// File: rtl/keypad_event_ctrl.sv
// Keypad debounce controller: samples the scanner once per ms tick, debounces
// press and release, and queues press/release events for a consumer.
module keypad_event_ctrl
    import keypad_pkg::*;
#(
    parameter int CLK_KHZ        = 25000,
    parameter int STABLE_SAMPLES = 4,
    parameter int FIFO_DEPTH     = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         enable,
    input  logic [KC_W-1:0]              key_code,
    output logic                         ev_valid,
    output logic [EV_W-1:0]              ev_data,
    input  logic                         ev_ready,
    output logic [$clog2(FIFO_DEPTH):0]  fifo_count,
    output logic                         overflow,
    input  logic                         ovf_clr,
    output logic                         key_held
);

    localparam int TW = (CLK_KHZ > 1) ? $clog2(CLK_KHZ) : 1;
    localparam int CW = $clog2(STABLE_SAMPLES + 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(CLK_KHZ - 1);
    localparam logic [CW-1:0] CNT_DONE  = CW'(STABLE_SAMPLES);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);

    logic [TW-1:0] tick_cnt;
    logic          tick;

    kp_state_t     state, state_n;
    key_t          cand, cand_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [CW-1:0] cnt_inc;
    logic          push;
    event_t        push_data;

    logic          key_present;
    key_t          key_val;
    logic          same_key;
    logic          stable;

    always_ff @(posedge clk) begin
        if (!rst) begin
            tick_cnt <= '0;
        end else if (!enable || tick) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + 1'b1;
        end
    end

    assign tick = enable && (tick_cnt == TICK_LAST);

    assign key_present = key_code[KC_PRESENT];
    assign key_val     = key_code[KC_KEY_MSB:KC_KEY_LSB];
    assign same_key    = key_present && (key_val == cand);
    assign cnt_inc     = cnt + 1'b1;
    assign stable      = (cnt_inc >= CNT_DONE);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= ST_IDLE;
            cand  <= '0;
            cnt   <= '0;
        end else begin
            state <= state_n;
            cand  <= cand_n;
            cnt   <= cnt_n;
        end
    end

    // NOTE: every output of this block is defaulted first so no path leaves one unassigned (no latches).
    always_comb begin
        state_n   = state;
        cand_n    = cand;
        cnt_n     = cnt;
        push      = 1'b0;
        push_data = '0;

        if (!enable) begin
            state_n = ST_IDLE;
            cnt_n   = '0;
        end else if (tick) begin
            case (state)
                ST_IDLE: begin
                    if (key_present) begin
                        cand_n  = key_val;
                        cnt_n   = CNT_ONE;
                        state_n = ST_DB_PRESS;
                    end
                end
                ST_DB_PRESS: begin
                    if (!key_present) begin
                        state_n = ST_IDLE;
                        cnt_n   = '0;
                    end else if (same_key) begin
                        if (stable) begin
                            push      = 1'b1;
                            push_data = make_event(EV_PRESS, cand);
                            state_n   = ST_HELD;
                            cnt_n     = '0;
                        end else begin
                            cnt_n = cnt_inc;
                        end
                    end else begin
                        // a different key restarts the press debounce on that key
                        cand_n = key_val;
                        cnt_n  = CNT_ONE;
                    end
                end
                ST_HELD: begin
                    if (!same_key) begin
                        cnt_n   = CNT_ONE;
                        state_n = ST_DB_REL;
                    end
                end
                ST_DB_REL: begin
                    if (same_key) begin
                        state_n = ST_HELD;
                        cnt_n   = '0;
                    end else if (stable) begin
                        push      = 1'b1;
                        push_data = make_event(EV_RELEASE, cand);
                        state_n   = ST_IDLE;
                        cnt_n     = '0;
                    end else begin
                        cnt_n = cnt_inc;
                    end
                end
                default: begin
                    state_n = ST_IDLE;
                    cnt_n   = '0;
                end
            endcase
        end
    end

    assign key_held = (state == ST_HELD) || (state == ST_DB_REL);

    keypad_evt_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (push_data),
        .ready     (ev_ready),
        .valid     (ev_valid),
        .head      (ev_data),
        .count     (fifo_count),
        .overflow  (overflow),
        .ovf_clr   (ovf_clr)
    );

endmodule

// File: tb/tb_keypad_event_ctrl.sv
// Self-checking bench for keypad_event_ctrl: directed scenarios plus a
// randomized run compared against a press/run-length reference model.
module tb_keypad_event_ctrl;

    localparam int CLK_KHZ = 4;
    localparam int STABLE  = 3;
    localparam int DEPTH   = 4;

    logic       clk;
    logic       rst;
    logic       enable;
    logic [4:0] key_code;
    logic       ev_valid;
    logic [4:0] ev_data;
    logic       ev_ready;
    logic [2:0] fifo_count;
    logic       overflow;
    logic       ovf_clr;
    logic       key_held;

    int vectors;
    int miscompares;

    // reference model: accepted key (-1 = none), candidate key, run length of qualifying samples
    int         m_phase;
    int         m_pressed;
    int         m_cand;
    int         m_run;
    bit         m_tick;
    bit         m_ovf;
    logic [4:0] m_q[$];

    keypad_event_ctrl #(
        .CLK_KHZ        (CLK_KHZ),
        .STABLE_SAMPLES (STABLE),
        .FIFO_DEPTH     (DEPTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .key_code   (key_code),
        .ev_valid   (ev_valid),
        .ev_data    (ev_data),
        .ev_ready   (ev_ready),
        .fifo_count (fifo_count),
        .overflow   (overflow),
        .ovf_clr    (ovf_clr),
        .key_held   (key_held)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic model_sample(input logic [4:0] code, output bit have, output logic [4:0] ev);
        bit present;
        int key;
        have    = 1'b0;
        ev      = '0;
        present = code[4];
        key     = int'(code[3:0]);
        if (m_pressed < 0) begin
            if (!present) begin
                m_run = 0;
            end else begin
                if (m_run > 0 && key == m_cand) m_run++;
                else begin
                    m_cand = key;
                    m_run  = 1;
                end
                if (m_run == STABLE) begin
                    have      = 1'b1;
                    ev        = {1'b1, 4'(m_cand)};
                    m_pressed = m_cand;
                    m_run     = 0;
                end
            end
        end else begin
            if (present && key == m_pressed) begin
                m_run = 0;
            end else begin
                m_run++;
                if (m_run == STABLE) begin
                    have      = 1'b1;
                    ev        = {1'b0, 4'(m_pressed)};
                    m_pressed = -1;
                    m_run     = 0;
                end
            end
        end
    endtask

    task automatic model_edge();
        bit         pop;
        bit         have;
        bit         dropped;
        logic [4:0] ev;
        m_tick  = 1'b0;
        have    = 1'b0;
        dropped = 1'b0;
        ev      = '0;
        if (!rst) begin
            m_phase   = 0;
            m_pressed = -1;
            m_cand    = 0;
            m_run     = 0;
            m_ovf     = 1'b0;
            m_q.delete();
            return;
        end
        pop = (m_q.size() != 0) && ev_ready;
        if (!enable) begin
            m_phase   = 0;
            m_pressed = -1;
            m_run     = 0;
        end else begin
            m_tick  = (m_phase == CLK_KHZ - 1);
            m_phase = (m_phase + 1) % CLK_KHZ;
            if (m_tick) model_sample(key_code, have, ev);
        end
        if (pop) void'(m_q.pop_front());
        if (have) begin
            if (m_q.size() < DEPTH) m_q.push_back(ev);
            else dropped = 1'b1;
        end
        if (dropped) m_ovf = 1'b1;
        else if (ovf_clr) m_ovf = 1'b0;
    endtask

    // one clock: DUT and model both update at the rising edge; caller resumes at the falling edge
    task automatic cycle();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic run_ticks(input logic [4:0] code, input int n);
        int seen  = 0;
        int guard = 0;
        key_code = code;
        while (seen < n && guard < 8 * n + 8) begin
            cycle();
            guard++;
            if (m_tick) seen++;
        end
        if (seen < n) begin
            vectors++; miscompares++;
            $display("FAIL tick_wait: got %0d ticks want %0d", seen, n);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0; enable = 1'b1; key_code = '0; ev_ready = 1'b0; ovf_clr = 1'b0;
        cycle();
        cycle();
        vectors++; if (ev_valid !== 1'b0)   begin miscompares++; $display("FAIL reset_valid: got %b want 0", ev_valid); end
        vectors++; if (ev_data !== 5'h00)   begin miscompares++; $display("FAIL reset_data: got %h want 00", ev_data); end
        vectors++; if (fifo_count !== 3'd0) begin miscompares++; $display("FAIL reset_count: got %0d want 0", fifo_count); end
        vectors++; if (overflow !== 1'b0)   begin miscompares++; $display("FAIL reset_ovf: got %b want 0", overflow); end
        vectors++; if (key_held !== 1'b0)   begin miscompares++; $display("FAIL reset_held: got %b want 0", key_held); end
        rst = 1'b1;
    endtask

    task automatic test_press();
        run_ticks(5'h15, 2);
        vectors++; if (fifo_count !== 3'd0) begin miscompares++; $display("FAIL press_early: got %0d want 0", fifo_count); end
        run_ticks(5'h15, 1);
        vectors++; if (fifo_count !== 3'd1) begin miscompares++; $display("FAIL press_count: got %0d want 1", fifo_count); end
        vectors++; if (ev_valid !== 1'b1)   begin miscompares++; $display("FAIL press_valid: got %b want 1", ev_valid); end
        vectors++; if (ev_data !== 5'h15)   begin miscompares++; $display("FAIL press_data: got %h want 15", ev_data); end
        vectors++; if (key_held !== 1'b1)   begin miscompares++; $display("FAIL press_held: got %b want 1", key_held); end
        ev_ready = 1'b1;
        cycle();
        ev_ready = 1'b0;
        vectors++; if (fifo_count !== 3'd0) begin miscompares++; $display("FAIL press_pop: got %0d want 0", fifo_count); end
    endtask

    task automatic test_release();
        run_ticks(5'h00, 2);
        vectors++; if (key_held !== 1'b1)   begin miscompares++; $display("FAIL rel_dbheld: got %b want 1", key_held); end
        vectors++; if (fifo_count !== 3'd0) begin miscompares++; $display("FAIL rel_early: got %0d want 0", fifo_count); end
        run_ticks(5'h00, 1);
        vectors++; if (ev_data !== 5'h05)   begin miscompares++; $display("FAIL rel_data: got %h want 05", ev_data); end
        vectors++; if (fifo_count !== 3'd1) begin miscompares++; $display("FAIL rel_count: got %0d want 1", fifo_count); end
        vectors++; if (key_held !== 1'b0)   begin miscompares++; $display("FAIL rel_held: got %b want 0", key_held); end
        ev_ready = 1'b1;
        cycle();
        ev_ready = 1'b0;
    endtask

    task automatic test_bounce();
        run_ticks(5'h13, 2);
        run_ticks(5'h00, 1);
        run_ticks(5'h13, 2);
        vectors++; if (fifo_count !== 3'd0) begin miscompares++; $display("FAIL bounce_count: got %0d want 0", fifo_count); end
        vectors++; if (key_held !== 1'b0)   begin miscompares++; $display("FAIL bounce_held: got %b want 0", key_held); end
        run_ticks(5'h00, 1);
    endtask

    task automatic test_overflow();
        for (int k = 1; k <= 5; k++) begin
            run_ticks({1'b1, 4'(k)}, 3);
            run_ticks(5'h00, 3);
        end
        vectors++; if (fifo_count !== 3'd4) begin miscompares++; $display("FAIL ovf_count: got %0d want 4", fifo_count); end
        vectors++; if (overflow !== 1'b1)   begin miscompares++; $display("FAIL ovf_flag: got %b want 1", overflow); end
        vectors++; if (ev_data !== 5'h11)   begin miscompares++; $display("FAIL ovf_head: got %h want 11", ev_data); end
        repeat (3) cycle();
        vectors++; if (ev_data !== 5'h11)   begin miscompares++; $display("FAIL ovf_stable: got %h want 11", ev_data); end
        ovf_clr = 1'b1;
        cycle();
        ovf_clr = 1'b0;
        vectors++; if (overflow !== 1'b0)   begin miscompares++; $display("FAIL ovf_clr: got %b want 0", overflow); end
        vectors++; if (fifo_count !== 3'd4) begin miscompares++; $display("FAIL ovf_clr_count: got %0d want 4", fifo_count); end
    endtask

    task automatic test_full_pop();
        int guard = 0;
        run_ticks(5'h17, 2);
        while (m_phase != CLK_KHZ - 1 && guard < 2 * CLK_KHZ) begin
            cycle();
            guard++;
        end
        ev_ready = 1'b1;
        cycle();
        ev_ready = 1'b0;
        vectors++; if (fifo_count !== 3'd4) begin miscompares++; $display("FAIL full_pop_count: got %0d want 4", fifo_count); end
        vectors++; if (overflow !== 1'b0)   begin miscompares++; $display("FAIL full_pop_ovf: got %b want 0", overflow); end
        vectors++; if (ev_data !== 5'h01)   begin miscompares++; $display("FAIL full_pop_head: got %h want 01", ev_data); end
        ev_ready = 1'b1;
        repeat (4) cycle();
        ev_ready = 1'b0;
        vectors++; if (fifo_count !== 3'd0) begin miscompares++; $display("FAIL drain_count: got %0d want 0", fifo_count); end
    endtask

    task automatic test_empty_push_pop();
        ev_ready = 1'b1;
        run_ticks(5'h00, 3);
        vectors++; if (fifo_count !== 3'd1) begin miscompares++; $display("FAIL empty_pp_count: got %0d want 1", fifo_count); end
        vectors++; if (ev_data !== 5'h07)   begin miscompares++; $display("FAIL empty_pp_data: got %h want 07", ev_data); end
        vectors++; if (key_held !== 1'b0)   begin miscompares++; $display("FAIL empty_pp_held: got %b want 0", key_held); end
        cycle();
        ev_ready = 1'b0;
        vectors++; if (fifo_count !== 3'd0) begin miscompares++; $display("FAIL empty_pp_pop: got %0d want 0", fifo_count); end
    endtask

    task automatic test_reset_mid();
        run_ticks(5'h1C, 3);
        run_ticks(5'h00, 3);
        run_ticks(5'h19, 2);
        vectors++; if (fifo_count !== 3'd2) begin miscompares++; $display("FAIL mid_pre_count: got %0d want 2", fifo_count); end
        rst = 1'b0;
        cycle();
        vectors++; if (ev_valid !== 1'b0)   begin miscompares++; $display("FAIL mid_valid: got %b want 0", ev_valid); end
        vectors++; if (ev_data !== 5'h00)   begin miscompares++; $display("FAIL mid_data: got %h want 00", ev_data); end
        vectors++; if (fifo_count !== 3'd0) begin miscompares++; $display("FAIL mid_count: got %0d want 0", fifo_count); end
        vectors++; if (key_held !== 1'b0)   begin miscompares++; $display("FAIL mid_held: got %b want 0", key_held); end
        rst = 1'b1;
        run_ticks(5'h19, 2);
        vectors++; if (fifo_count !== 3'd0) begin miscompares++; $display("FAIL mid_after: got %0d want 0", fifo_count); end
        run_ticks(5'h00, 1);
    endtask

    task automatic test_enable();
        run_ticks(5'h1E, 3);
        enable   = 1'b0;
        key_code = 5'h00;
        repeat (20) cycle();
        vectors++; if (key_held !== 1'b0)   begin miscompares++; $display("FAIL dis_held: got %b want 0", key_held); end
        vectors++; if (fifo_count !== 3'd1) begin miscompares++; $display("FAIL dis_count: got %0d want 1", fifo_count); end
        vectors++; if (ev_data !== 5'h1E)   begin miscompares++; $display("FAIL dis_data: got %h want 1e", ev_data); end
        enable = 1'b1;
        run_ticks(5'h00, 3);
        vectors++; if (fifo_count !== 3'd1) begin miscompares++; $display("FAIL dis_norel: got %0d want 1", fifo_count); end
        ev_ready = 1'b1;
        cycle();
        ev_ready = 1'b0;
    endtask

    task automatic test_random();
        logic [4:0] codes [4];
        int         hold;
        logic [4:0] exp_data;
        codes[0] = 5'h00; codes[1] = 5'h13; codes[2] = 5'h15; codes[3] = 5'h1A;
        hold = 0;
        for (int i = 0; i < 3000; i++) begin
            if (hold == 0) begin
                key_code = codes[$urandom_range(0, 3)];
                hold     = $urandom_range(2, 24);
            end
            hold--;
            ev_ready = ($urandom_range(0, 3) == 0);
            ovf_clr  = ($urandom_range(0, 15) == 0);
            enable   = ($urandom_range(0, 199) != 0);
            rst      = ($urandom_range(0, 499) != 0);
            cycle();
            exp_data = (m_q.size() != 0) ? m_q[0] : 5'h00;
            vectors++; if (ev_valid !== (m_q.size() != 0))  begin miscompares++; $display("FAIL rnd_valid @%0d: got %b want %b", i, ev_valid, m_q.size() != 0); end
            vectors++; if (ev_data !== exp_data)            begin miscompares++; $display("FAIL rnd_data @%0d: got %h want %h", i, ev_data, exp_data); end
            vectors++; if (fifo_count !== 3'(m_q.size()))   begin miscompares++; $display("FAIL rnd_count @%0d: got %0d want %0d", i, fifo_count, m_q.size()); end
            vectors++; if (overflow !== m_ovf)              begin miscompares++; $display("FAIL rnd_ovf @%0d: got %b want %b", i, overflow, m_ovf); end
            vectors++; if (key_held !== (m_pressed >= 0))   begin miscompares++; $display("FAIL rnd_held @%0d: got %b want %b", i, key_held, m_pressed >= 0); end
        end
        rst = 1'b1; enable = 1'b1; ev_ready = 1'b0; ovf_clr = 1'b0;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        m_phase     = 0;
        m_pressed   = -1;
        m_cand      = 0;
        m_run       = 0;
        m_tick      = 1'b0;
        m_ovf       = 1'b0;
        rst = 1'b0; enable = 1'b1; key_code = '0; ev_ready = 1'b0; ovf_clr = 1'b0;
        @(negedge clk);
        test_reset();
        test_press();
        test_release();
        test_bounce();
        test_overflow();
        test_full_pop();
        test_empty_push_pop();
        test_reset_mid();
        test_enable();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/keypad_event_ctrl.md
KEYPAD_EVENT_CTRL -- requirements
Module: keypad_event_ctrl

Interface
REQ-001 SHALL have parameter CLK_KHZ, default 25000, giving clock cycles per 1 ms sample tick.
REQ-002 SHALL have parameter STABLE_SAMPLES, default 4, giving consecutive identical samples needed to accept a press or release.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, giving event queue depth (power of two, at least 2).
REQ-004 SHALL have port `clk`, input, 1 bit: single clock, rising edge.
REQ-005 SHALL have port `rst`, input, 1 bit: synchronous, active-low reset.
REQ-006 SHALL have port `enable`, input, 1 bit: scanning and debounce enable.
REQ-007 SHALL have port `key_code`, input, 5 bits: scanner output; [4] = key present, [3:0] = key value 0x0-0xF.
REQ-008 SHALL have port `ev_valid`, output, 1 bit: head event available.
REQ-009 SHALL have port `ev_data`, output, 5 bits: head event; [4] = 1 press / 0 release, [3:0] = key.
REQ-010 SHALL have port `ev_ready`, input, 1 bit: consumer accepts the head event.
REQ-011 SHALL have port `fifo_count`, output, clog2(FIFO_DEPTH)+1 bits: occupancy.
REQ-012 SHALL have port `overflow`, output, 1 bit: sticky flag, set when an event was dropped.
REQ-013 SHALL have port `ovf_clr`, input, 1 bit: clears `overflow`.
REQ-014 SHALL have port `key_held`, output, 1 bit: high while the FSM is in HELD or DB_REL.

Function
REQ-015 Tick counter SHALL count 0..CLK_KHZ-1 and assert tick for one cycle at CLK_KHZ-1, then wrap to 0.
REQ-016 With `enable`=0: counter held at 0, no ticks, FSM forced to IDLE, no event generated, FIFO contents retained.
REQ-017 `key_code` SHALL be sampled only on tick cycles; between ticks the FSM holds state.
REQ-018 FSM states SHALL be IDLE, DB_PRESS, HELD and DB_REL.
REQ-019 IDLE: on a tick with key_code[4]=1, latch cand=key_code[3:0], cnt=1, go to DB_PRESS.
REQ-020 DB_PRESS, tick with key_code={1,cand}: cnt+1; when cnt reaches STABLE_SAMPLES, push {1,cand} and go to HELD.
REQ-021 DB_PRESS, tick with a different present key: cand=new key, cnt=1, stay in DB_PRESS.
REQ-022 DB_PRESS, tick with key_code[4]=0: go to IDLE, no event.
REQ-023 HELD, tick with key_code≠{1,cand}: cnt=1, go to DB_REL.
REQ-024 DB_REL, tick with key_code={1,cand}: go to HELD, no event.
REQ-025 DB_REL, other tick: cnt+1; when cnt reaches STABLE_SAMPLES, push {0,cand} and go to IDLE.
REQ-026 A direct change from key A to key B SHALL yield a release of A, then a debounced press of B starting at the next tick.
REQ-027 FIFO SHALL be first-word-fall-through: `ev_valid` = (count≠0), `ev_data` = head; a pushed event is visible on the cycle after the push.
REQ-028 Pop SHALL occur when `ev_valid` and `ev_ready` are both high in the same cycle; `ev_data` SHALL be stable while `ev_valid`=1 and `ev_ready`=0.
REQ-029 Push when full with no pop: event dropped, `overflow`=1; push with simultaneous pop when full: push accepted, count unchanged.
REQ-030 Push and pop together when empty: push accepted, count becomes 1 (no bypass).
REQ-031 `ovf_clr` SHALL clear `overflow`; if an overflow occurs in the same cycle, set SHALL win.
REQ-032 Pointers SHALL wrap modulo FIFO_DEPTH.

Reset
REQ-033 With `rst`=0 at a rising edge: FSM=IDLE, cnt=0, tick counter=0, FIFO empty, `ev_valid`=0, `ev_data`=0, `fifo_count`=0, `overflow`=0, `key_held`=0.
REQ-034 Reset mid-debounce or mid-hold SHALL discard the pending state without emitting an event.

Structure
REQ-035 Package keypad_pkg SHALL hold the FSM state encoding, EV_PRESS/EV_RELEASE bit constants and the 5-bit key_code field positions.
REQ-036 The FIFO SHALL be a sub-module named keypad_evt_fifo (parameter DEPTH, width 5).

Verification (CLK_KHZ=4, STABLE_SAMPLES=3, FIFO_DEPTH=4)
REQ-037 Bench SHALL cover: key_code=0x15 held 3 ticks -> exactly one event 0x15, key_held=1.
REQ-038 Bench SHALL cover: key 5 held, then key_code=0x00 for 3 ticks -> event 0x05, key_held=0.
REQ-039 Bench SHALL cover: 0x13 for 2 ticks, 0x00 for 1 tick, 0x13 for 2 ticks -> no event.
REQ-040 Bench SHALL cover: 5 press/release pairs with ev_ready=0 -> fifo_count=4, overflow=1, head=first press; ovf_clr -> overflow=0.
REQ-041 Bench SHALL cover: full FIFO with ev_ready=1 on a push cycle -> count stays 4, no overflow.
REQ-042 Bench SHALL cover: rst=0 during DB_PRESS (cnt=2) -> all outputs 0, no event after release of reset.
